// File: rtl/usb_fx3_pkg.sv
// Shared definitions for the FX3 slave-FIFO front-ends.
//   - master_mode encodings that select which front-end owns the FX3 pins
//   - stream-out FSM state encodings (also visible on current_stream_out_mode)
//   - FX3 socket address constants and the DQ bus width
package usb_fx3_pkg;

   localparam int unsigned DqWidth = 32;

   typedef enum logic [2:0] {
      ModeLoopback  = 3'b000,
      ModeStreamOut = 3'b001,
      ModeStreamIn  = 3'b010,
      ModePartial   = 3'b011,
      ModeZlp       = 3'b100,
      ModeIdle      = 3'b101
   } master_mode_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArm   = 2'b01,
      StRead  = 2'b10,
      StDrain = 2'b11
   } stream_out_state_e;

   localparam logic [1:0] SockStreamIn  = 2'b00;
   localparam logic [1:0] SockStreamOut = 2'b11;

endpackage

// File: rtl/usb_stream_out_if.sv
// FX3 slave-FIFO pins plus the downstream valid/ready word stream.
//   master: the stream-out block (drives FX3 controls and the downstream word)
//   slave : the FX3 device / downstream consumer side
//   FX3 pins  : SLCS, SLOE, SLRD, SLWR, PKTEND, A (to FX3); FLAGC, FLAGD, DQ (from FX3)
//   Downstream: data_in, data_valid (to consumer); data_ready (from consumer)
interface usb_stream_out_if;
   import usb_fx3_pkg::*;

   logic               SLCS;
   logic               SLOE;
   logic               SLRD;
   logic               SLWR;
   logic               PKTEND;
   logic [1:0]         A;
   logic               FLAGC;
   logic               FLAGD;
   logic [DqWidth-1:0] DQ;
   logic [DqWidth-1:0] data_in;
   logic               data_valid;
   logic               data_ready;

   modport master (
      output SLCS, SLOE, SLRD, SLWR, PKTEND, A, data_in, data_valid,
      input  FLAGC, FLAGD, DQ, data_ready
   );

   modport slave (
      input  SLCS, SLOE, SLRD, SLWR, PKTEND, A, data_in, data_valid,
      output FLAGC, FLAGD, DQ, data_ready
   );

endinterface

// File: rtl/usb_stream_out_fifo.sv
// Synchronous capture FIFO, Depth x Width, with occupancy count.
//   clk, rst_n    : clock, synchronous active-low reset (pointers and count only)
//   push, wdata   : write request and data
//   pop, rdata    : read request and head-of-queue data (valid when !empty)
//   empty, full   : status
//   count         : words currently stored
// A pop on an empty FIFO is ignored; push and pop together on a full FIFO both happen.
module usb_stream_out_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [Width-1:0]       wdata,
   input  logic                   pop,
   output logic [Width-1:0]       rdata,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(Depth):0] count
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = AddrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AddrW'(1);
         if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/usb_stream_out.sv
// FX3 slave-FIFO read-socket reader: pulls 32-bit words from FX3 and hands them
// downstream on a valid/ready stream, active only while master_mode selects stream-out.
//   clk, rst_n              : clock, synchronous active-low reset
//   master_mode             : front-end select; this block runs only for ModeStreamOut
//   bus (master)            : FX3 pins and downstream stream, see usb_stream_out_if
//   current_stream_out_mode : FSM state for debug
//   word_count              : downstream handshake counter, present only when
//                             USB_STREAM_OUT_WORD_COUNT_EN is defined
module usb_stream_out
   import usb_fx3_pkg::*;
#(
   parameter int unsigned READ_LAT   = 2,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [1:0]  SOCK_ADDR  = SockStreamOut
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          master_mode,
   usb_stream_out_if.master    bus,
   output logic [1:0]          current_stream_out_mode
`ifdef USB_STREAM_OUT_WORD_COUNT_EN
   ,
   output logic [31:0]         word_count
`endif
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OccW = CntW + 1;

   stream_out_state_e    state_q, state_d;
   logic                 slcs_q, slcs_d, sloe_q, sloe_d, slrd_q, slrd_d;
   logic [1:0]           a_q;
   logic [READ_LAT-1:0]  mark_q, mark_d;
   logic [CntW-1:0]      inflight, fifo_count;
   logic [OccW-1:0]      occupancy;
   logic                 mode_ok, room, issue;
   logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic                 data_valid;
   logic [DqWidth-1:0]   fifo_rdata;

   assign mode_ok = (master_mode == ModeStreamOut);

   // A strobe already on the SLRD pin has not reached the mark register yet, so it
   // counts as in flight; otherwise a full FIFO could be overrun by one word.
   always_comb begin
      inflight = CntW'(!slrd_q);
      for (int i = 0; i < READ_LAT; i++) inflight = inflight + CntW'(mark_q[i]);
   end

   assign occupancy = OccW'(fifo_count) + OccW'(inflight);
   assign room      = (occupancy < OccW'(FIFO_DEPTH));

   // Marks follow the strobe as FX3 samples it; the word is on DQ as a mark leaves.
   always_comb begin
      mark_d    = mark_q;
      mark_d[0] = !slrd_q;
      for (int i = 1; i < READ_LAT; i++) mark_d[i] = mark_q[i-1];
   end

   assign fifo_push = mark_q[READ_LAT-1];

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: if (mode_ok) state_d = StArm;
         StArm: begin
            if (!mode_ok) state_d = StIdle;
            else if (bus.FLAGC && bus.FLAGD) state_d = StRead;
         end
         StRead: begin
            issue = bus.FLAGD && mode_ok && room;
            if (!bus.FLAGD || !mode_ok) state_d = StDrain;
         end
         StDrain: if (inflight == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Pin levels follow the state being entered so they line up with state_q.
      slcs_d = (state_d == StIdle);
      sloe_d = !((state_d == StRead) || (state_d == StDrain));
      slrd_d = !issue;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         slcs_q  <= 1'b1;
         sloe_q  <= 1'b1;
         slrd_q  <= 1'b1;
         a_q     <= SOCK_ADDR;
         mark_q  <= '0;
      end else begin
         state_q <= state_d;
         slcs_q  <= slcs_d;
         sloe_q  <= sloe_d;
         slrd_q  <= slrd_d;
         a_q     <= SOCK_ADDR;
         mark_q  <= mark_d;
      end
   end

   usb_stream_out_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (DqWidth)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (bus.DQ),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign data_valid = !fifo_empty;
   assign fifo_pop   = data_valid && bus.data_ready;

   assign bus.SLCS       = slcs_q;
   assign bus.SLOE       = sloe_q;
   assign bus.SLRD       = slrd_q;
   assign bus.SLWR       = 1'b1;
   assign bus.PKTEND     = 1'b1;
   assign bus.A          = a_q;
   assign bus.data_valid = data_valid;
   assign bus.data_in    = fifo_rdata;

   assign current_stream_out_mode = state_q;

`ifdef USB_STREAM_OUT_WORD_COUNT_EN
   logic [31:0] word_count_q;

   // Cleared while parked in IDLE under another mode; buffered words may still drain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_count_q <= '0;
      end else if ((state_q == StIdle) && !mode_ok) begin
         word_count_q <= '0;
      end else if (fifo_pop) begin
         word_count_q <= word_count_q + 32'd1;
      end
   end

   assign word_count = word_count_q;
`endif

endmodule
